alu_mdu_ctrl: RTL and testbench
===============================

# alu_mdu_ctrl

Parametrised ALU control and execute block with an integrated iterative multiply/divide unit (MDU). It replaces the purely combinational funct/ALU-op decoder. It decodes the control-unit ALU op and the R-type funct field, then executes the operation on WIDTH-bit operands. Single-cycle ops return a registered result. MULT/MULTU/DIV/DIVU run over multiple cycles and write the HI/LO registers. A valid/ready handshake toward the decode stage stalls issue while the MDU is busy.

## Interface
- WIDTH, 32: operand/result width in bits; ≥ 4.
- CNT_W, $clog2(WIDTH): width of the MDU step counter.

- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept; equals !busy.
- alu_op  in  3  control-unit op: 000 ADD, 001 SUB, 010 R-type (use funct), 011 AND, 100 OR, 101 SLT; 110/111 illegal.
- funct  in  6  R-type function field.
- a, b  in  WIDTH  operands (rs, rt).
- result  out  WIDTH  registered result.
- zero  out  1  registered, result == 0.
- out_valid  out  1  one-cycle pulse, result valid.
- out_err  out  1  qualifies out_valid: illegal op/funct, or divide by zero.
- busy  out  1  MDU operation in progress.
- hi, lo  out  WIDTH  architectural HI/LO registers.

## Operation
- Accept when in_valid && in_ready at a rising edge; operands and decoded op are captured at that edge.
- Single-cycle R-type funct codes: 100100 AND, 100101 OR, 100000 ADD, 100010 SUB, 101010 SLT (signed), 100110 XOR, 100111 NOR, 010000 MFHI, 010010 MFLO.
- Arithmetic is modulo 2^WIDTH with no overflow trap. SLT returns 1 or 0, zero-extended.
- MFHI/MFLO return hi/lo as they stand at the accept edge.
- MDU funct codes: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU. For these, result = new LO value.
- MULT/MULTU: shift-add over a 2·WIDTH product, one bit per cycle. hi = upper half, lo = lower half.
- DIV/DIVU: restoring division, one quotient bit per cycle. lo = quotient, hi = remainder.
- Signed DIV operates on magnitudes. The quotient is negated if the operand signs differ. The remainder takes the sign of a.
- Divide by zero: lo = all ones, hi = a, out_err = 1.
- Signed most-negative / −1: lo = most-negative, hi = 0, out_err = 0.
- Illegal alu_op or unknown funct: result = 0, out_err = 1. hi/lo are unchanged.
- FSM states:
  - IDLE: accepting; an MDU op moves to RUN, all other ops stay in IDLE.
  - RUN: busy; counter loaded with WIDTH−1 and decremented each cycle; at count 0, commit hi/lo, pulse out_valid, return to IDLE.

## Timing
- Reset values: result 0, zero 1, out_valid 0, out_err 0, busy 0, hi 0, lo 0, state IDLE.
- Reset asserted mid-RUN aborts the operation: no out_valid, hi/lo cleared.
- Single-cycle op latency: 1. out_valid is high in the cycle after the accept edge.
- MDU latency: WIDTH+1 edges from the accept edge to out_valid; busy is high for exactly WIDTH cycles.
- hi/lo update on the same edge that raises out_valid for an MDU op.
- in_ready rises in the cycle in which MDU out_valid is high, so back-to-back issue is allowed.
- Single-cycle ops may be accepted on consecutive cycles, giving one result per cycle.
- in_valid while busy is ignored; the inputs are not captured.
- MFHI accepted in the cycle that an MDU out_valid is high returns the new hi.
- result/zero hold their value between out_valid pulses.

## Test plan
- Reset → all outputs at their reset values. Then alu_op=010, funct=100000, a=5, b=7 → 1 cycle later: result=12, out_valid=1, zero=0.
- alu_op=010, funct=101010, a=0xFFFFFFFF, b=1 → result=1. Same with funct=100111, a=0, b=0 → result=0xFFFFFFFF.
- MULT a=0xFFFFFFFF, b=2 → busy for 32 cycles, out_valid at edge 33: hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=1, lo=0xFFFFFFFE.
- DIV a=−7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=9, b=0 → lo=0xFFFFFFFF, hi=9, out_err=1.
- in_valid held high with ADD during MDU RUN → in_ready=0, nothing captured. The ADD is accepted in the out_valid cycle. MFHI issued right after returns the new hi.
- rst_n low at RUN cycle 10 → no out_valid, busy=0, hi=lo=0. Also: alu_op=111 → result=0, out_err=1.

Source files
------------

// File: rtl/alu_mdu_ctrl.sv
// rtl/alu_mdu_ctrl.sv - ALU control/execute block with iterative multiply/divide unit
// Single-cycle ALU ops return a registered result; MULT/DIV variants iterate one bit per cycle into HI/LO.
module alu_mdu_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             out_valid,
  output logic             out_err,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;

  logic             accept;
  logic             is_mdu;
  logic             dec_err;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] slt_res;

  // MDU working registers: acc is product-high / remainder, qr is multiplier / quotient
  logic [WIDTH-1:0] acc, qr, opd, a_q;
  logic [CNT_W-1:0] cnt;
  logic             is_div, neg_q, neg_r, div0;

  logic             sgn;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] acc_nxt, qr_nxt;
  logic [2*WIDTH-1:0] prod, prod_fin;
  logic [WIDTH-1:0] hi_fin, lo_fin;

  assign busy     = (state == RUN);
  assign in_ready = !busy;
  assign accept   = in_valid && in_ready;
  assign slt_res  = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};

  always_comb begin
    alu_res = '0;
    dec_err = 1'b0;
    is_mdu  = 1'b0;
    case (alu_op)
      3'b000: alu_res = a + b;
      3'b001: alu_res = a - b;
      3'b011: alu_res = a & b;
      3'b100: alu_res = a | b;
      3'b101: alu_res = slt_res;
      3'b010: begin
        case (funct)
          F_AND:  alu_res = a & b;
          F_OR:   alu_res = a | b;
          F_ADD:  alu_res = a + b;
          F_SUB:  alu_res = a - b;
          F_SLT:  alu_res = slt_res;
          F_XOR:  alu_res = a ^ b;
          F_NOR:  alu_res = ~(a | b);
          F_MFHI: alu_res = hi;
          F_MFLO: alu_res = lo;
          F_MULT, F_MULTU, F_DIV, F_DIVU: is_mdu = 1'b1;
          default: dec_err = 1'b1;
        endcase
      end
      default: dec_err = 1'b1;
    endcase
  end

  // Signed variants run on magnitudes; funct[0] clear marks the signed forms
  assign sgn   = !funct[0];
  assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;

  assign mul_sum  = {1'b0, acc} + (qr[0] ? {1'b0, opd} : '0);
  assign div_sh   = {acc, qr[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opd};

  always_comb begin
    acc_nxt = mul_sum[WIDTH:1];
    qr_nxt  = {mul_sum[0], qr[WIDTH-1:1]};
    if (is_div) begin
      acc_nxt = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      qr_nxt  = {qr[WIDTH-2:0], !div_diff[WIDTH]};
    end
  end

  assign prod     = {acc_nxt, qr_nxt};
  assign prod_fin = neg_q ? -prod : prod;

  always_comb begin
    hi_fin = prod_fin[2*WIDTH-1:WIDTH];
    lo_fin = prod_fin[WIDTH-1:0];
    if (is_div) begin
      hi_fin = neg_r ? -acc_nxt : acc_nxt;
      lo_fin = neg_q ? -qr_nxt : qr_nxt;
      if (div0) begin
        hi_fin = a_q;
        lo_fin = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && is_mdu) state_nxt = RUN;
      RUN:  if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      acc       <= '0;
      qr        <= '0;
      opd       <= '0;
      a_q       <= '0;
      cnt       <= '0;
      is_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div0      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      if (accept && !is_mdu) begin
        result    <= alu_res;
        zero      <= (alu_res == '0);
        out_valid <= 1'b1;
        out_err   <= dec_err;
      end
      if (accept && is_mdu) begin
        is_div <= funct[1];
        neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r  <= sgn && a[WIDTH-1];
        div0   <= funct[1] && (b == '0);
        a_q    <= a;
        acc    <= '0;
        qr     <= a_mag;
        opd    <= b_mag;
        cnt    <= CNT_W'(WIDTH-1);
      end
      if (state == RUN) begin
        acc <= acc_nxt;
        qr  <= qr_nxt;
        cnt <= cnt - CNT_W'(1);
        if (cnt == '0) begin
          hi        <= hi_fin;
          lo        <= lo_fin;
          result    <= lo_fin;
          zero      <= (lo_fin == '0);
          out_valid <= 1'b1;
          out_err   <= div0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// tb/tb_alu_mdu_ctrl.sv - directed self-checking bench for alu_mdu_ctrl
module tb_alu_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] a, b;
  logic [31:0] result;
  logic        zero, out_valid, out_err, busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int edges, bcnt, rdy_bad, ov_cnt;

  alu_mdu_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .a(a), .b(b),
    .result(result), .zero(zero), .out_valid(out_valid), .out_err(out_err),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [5:0] fn,
                       input logic [31:0] va, input logic [31:0] vb);
    alu_op = op; funct = fn; a = va; b = vb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_mdu(output int n, output int bc, output int rb);
    n = 0; bc = 0; rb = 0;
    while (!out_valid && n < 40) begin
      if (busy) bc++;
      if (busy && in_ready) rb++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; alu_op = 3'b000; funct = 6'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst_n = 1'b1;

    do_op(3'b010, 6'b100000, 32'd5, 32'd7);
    chk("add_result", result, 12);
    chk("add_valid", out_valid, 1);
    chk("add_zero", zero, 0);
    chk("add_err", out_err, 0);
    do_op(3'b010, 6'b101010, 32'hFFFFFFFF, 32'd1);
    chk("slt_result", result, 1);
    chk("slt_valid_b2b", out_valid, 1);
    do_op(3'b010, 6'b100111, 32'd0, 32'd0);
    chk("nor_result", result, 32'hFFFFFFFF);
    do_op(3'b001, 6'b000000, 32'd3, 32'd5);
    chk("sub_wrap", result, 32'hFFFFFFFE);
    do_op(3'b010, 6'b100110, 32'hF0F0F0F0, 32'hFF00FF00);
    chk("xor_result", result, 32'h0FF00FF0);
    do_op(3'b010, 6'b100010, 32'd5, 32'd5);
    chk("sub_zero_res", result, 0);
    chk("sub_zero_flag", zero, 1);
    @(posedge clk); #1;
    chk("valid_pulse_drop", out_valid, 0);
    chk("result_hold", result, 0);

    do_op(3'b010, 6'b011000, 32'hFFFFFFFF, 32'd2);
    chk("mult_busy", busy, 1);
    chk("mult_in_ready", in_ready, 0);
    wait_mdu(edges, bcnt, rdy_bad);
    chk("mult_edges", edges, 32);
    chk("mult_busy_cycles", bcnt, 32);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFE);
    chk("mult_result", result, 32'hFFFFFFFE);
    chk("mult_err", out_err, 0);
    chk("mult_ready_back", in_ready, 1);

    do_op(3'b010, 6'b011001, 32'hFFFFFFFF, 32'd2);
    wait_mdu(edges, bcnt, rdy_bad);
    chk("multu_hi", hi, 1);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    do_op(3'b010, 6'b011010, 32'hFFFFFFF9, 32'd2);
    wait_mdu(edges, bcnt, rdy_bad);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_err", out_err, 0);

    do_op(3'b010, 6'b011011, 32'd9, 32'd0);
    wait_mdu(edges, bcnt, rdy_bad);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 9);
    chk("divu0_err", out_err, 1);
    chk("divu0_valid", out_valid, 1);

    do_op(3'b010, 6'b011010, 32'h80000000, 32'hFFFFFFFF);
    wait_mdu(edges, bcnt, rdy_bad);
    chk("divmin_lo", lo, 32'h80000000);
    chk("divmin_hi", hi, 0);
    chk("divmin_err", out_err, 0);

    do_op(3'b010, 6'b011011, 32'd100, 32'd7);
    wait_mdu(edges, bcnt, rdy_bad);
    chk("divu_lo", lo, 14);
    chk("divu_hi", hi, 2);

    do_op(3'b010, 6'b011001, 32'hFFFFFFFF, 32'd3);
    alu_op = 3'b010; funct = 6'b100000; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    wait_mdu(edges, bcnt, rdy_bad);
    chk("stall_edges", edges, 32);
    chk("stall_ready_low", rdy_bad, 0);
    chk("stall_result_lo", result, 32'hFFFFFFFD);
    chk("stall_hi", hi, 2);
    chk("stall_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("stall_add_valid", out_valid, 1);
    chk("stall_add_result", result, 2);
    do_op(3'b010, 6'b010000, 32'd0, 32'd0);
    chk("mfhi_result", result, 2);
    do_op(3'b010, 6'b010010, 32'd0, 32'd0);
    chk("mflo_result", result, 32'hFFFFFFFD);

    do_op(3'b111, 6'b100000, 32'd4, 32'd4);
    chk("illop_result", result, 0);
    chk("illop_err", out_err, 1);
    chk("illop_valid", out_valid, 1);
    chk("illop_hi_kept", hi, 2);
    do_op(3'b010, 6'b111111, 32'd4, 32'd4);
    chk("illfn_err", out_err, 1);
    chk("illfn_lo_kept", lo, 32'hFFFFFFFD);

    do_op(3'b010, 6'b011000, 32'd7, 32'd9);
    repeat (9) begin @(posedge clk); #1; end
    chk("midrun_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    rst_n = 1'b1;
    ov_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) ov_cnt++;
    end
    chk("abort_no_valid", ov_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
